boxhead_pio_out_pulse: RTL

Parametrised Avalon-MM output PIO. It is the successor to the fixed 1-bit chip-select/control ports used for the OTG HPI lines.
- Provides a WIDTH-bit output register with atomic set, clear and toggle writes.
- Adds a hardware pulse engine that inverts selected bits for a programmed number of clk cycles, then restores them automatically.
- Sits on the SoC Avalon bus and drives external control strobes (HPI cs/rd/wr/rst, peripheral enables) without CPU-timed bit-banging.

---
 rtl/boxhead_pio_out_pulse.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/boxhead_pio_out_pulse.sv
// Avalon-MM output PIO with atomic set/clear/toggle writes and a self-restoring pulse engine.
// Optional BOXHEAD_PIO_SHADOW_EN: writes stage into a shadow register, committed by a write to address 7.
module boxhead_pio_out_pulse #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int unsigned PULSE_CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             pulse_busy
);

    localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pulse_state_t;

    pulse_state_t           state_q, state_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic [WIDTH-1:0]       mask_q, mask_d;
    logic [WIDTH-1:0]       out_d;
    logic [PULSE_CNT_W-1:0] len_q, len_d;
    logic [PULSE_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]       wr_base_c;
    logic [WIDTH-1:0]       wr_val_c;
    logic                   wr_hit_c;
    logic                   wr_en_c;
    logic                   pulse_wr_c;
    logic [WIDTH-1:0]       wd_c;
    logic                   unused_wd;

    assign wr_en_c    = chipselect & ~write_n;
    assign pulse_wr_c = wr_en_c && (address == 3'd2);
    assign wd_c       = writedata[WIDTH-1:0];
    assign unused_wd  = ^writedata;

`ifdef BOXHEAD_PIO_SHADOW_EN
    logic [WIDTH-1:0] shadow_q, shadow_d;
    assign wr_base_c = shadow_q;
`else
    assign wr_base_c = data_q;
`endif

    // Atomic read-modify-write value for DATA/OUTSET/OUTCLEAR/TOGGLE
    always_comb begin
        wr_val_c = wr_base_c;
        wr_hit_c = 1'b0;
        if (wr_en_c) begin
            case (address)
                3'd0: begin wr_val_c = wd_c;               wr_hit_c = 1'b1; end
                3'd4: begin wr_val_c = wr_base_c | wd_c;   wr_hit_c = 1'b1; end
                3'd5: begin wr_val_c = wr_base_c & ~wd_c;  wr_hit_c = 1'b1; end
                3'd6: begin wr_val_c = wr_base_c ^ wd_c;   wr_hit_c = 1'b1; end
                default: ;
            endcase
        end
    end

    // Register next-state: data/shadow, pulse length
    always_comb begin
        data_d = data_q;
        len_d  = len_q;
`ifdef BOXHEAD_PIO_SHADOW_EN
        shadow_d = shadow_q;
        if (wr_hit_c) shadow_d = wr_val_c;
        if (wr_en_c && (address == 3'd7)) data_d = shadow_q;
`else
        if (wr_hit_c) data_d = wr_val_c;
`endif
        if (wr_en_c && (address == 3'd1)) len_d = writedata[PULSE_CNT_W-1:0];
    end

    // Pulse engine; a PULSE write takes priority over the decrement on the same edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                if (pulse_wr_c && (len_q != '0)) begin
                    mask_d  = wd_c;
                    cnt_d   = len_q;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (pulse_wr_c) begin
                    if (len_q != '0) begin
                        mask_d = wd_c;
                        cnt_d  = len_q;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - PULSE_CNT_W'(1);
                    if (cnt_q == PULSE_CNT_W'(1)) state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        out_d = data_d ^ ((cnt_d != '0) ? mask_d : '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            data_q   <= RST_VAL;
            mask_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            out_port <= RST_VAL;
`ifdef BOXHEAD_PIO_SHADOW_EN
            shadow_q <= RST_VAL;
`endif
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            out_port <= out_d;
`ifdef BOXHEAD_PIO_SHADOW_EN
            shadow_q <= shadow_d;
`endif
        end
    end

    assign pulse_busy = (state_q == ACTIVE);

    // Zero-latency read mux, decoded from address alone
    always_comb begin
        readdata = '0;
        case (address)
            3'd0:             readdata = 32'(out_port);
            3'd1:             readdata = 32'(len_q);
            3'd2:             readdata = 32'(cnt_q);
            3'd4, 3'd5, 3'd6: readdata = 32'(wr_base_c);
`ifdef BOXHEAD_PIO_SHADOW_EN
            3'd7:             readdata = 32'(shadow_q);
`endif
            default:          readdata = '0;
        endcase
    end

endmodule
